// File: rtl/tlc_pkg.sv
// Shared types and constants for the traffic-light lamp monitor.
package tlc_pkg;

    localparam int unsigned NUM_LIGHTS = 6;
    localparam int unsigned NUM_PAIRS  = 15;
    localparam int unsigned LAMP_W     = 3 * NUM_LIGHTS;

    typedef enum logic [1:0] {
        GREEN  = 2'd0,
        YELLOW = 2'd1,
        RED    = 2'd2,
        BAD    = 2'd3
    } light_e;

    typedef enum logic [2:0] {
        F_NONE         = 3'd0,
        F_ILLEGAL      = 3'd1,
        F_CONFLICT     = 3'd2,
        F_TRANSITION   = 3'd3,
        F_SHORT_YELLOW = 3'd4
    } fault_e;

    typedef enum logic [1:0] {
        ST_ARM     = 2'd0,
        ST_MONITOR = 2'd1,
        ST_FAULT   = 2'd2
    } state_e;

    // Zero-based light indices of each conflict pair, in CONFLICT_PAIRS bit order.
    localparam int unsigned PAIR_LO [NUM_PAIRS] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 3, 3, 4};
    localparam int unsigned PAIR_HI [NUM_PAIRS] = '{1, 2, 3, 4, 5, 2, 3, 4, 5, 3, 4, 5, 4, 5, 5};

    // All lamps red at the given phase, yellow and green dark.
    function automatic logic [LAMP_W-1:0] lamp_flash(input logic phase);
        return {NUM_LIGHTS{phase, 2'b00}};
    endfunction

endpackage

// File: rtl/tlc_lamp_monitor_if.sv
// Light-code inputs, clear request and lamp/fault outputs of the monitor.
interface tlc_lamp_monitor_if;
    import tlc_pkg::*;

    logic [1:0]        TL1;
    logic [1:0]        TL2;
    logic [1:0]        TL3;
    logic [1:0]        TL4;
    logic [1:0]        TL5;
    logic [1:0]        TL6;
    logic              fault_clr;
    logic [LAMP_W-1:0] lamp_out;
    logic              fault_o;
    logic [2:0]        fault_code;
    logic [2:0]        fault_light;

    modport master (
        output TL1, TL2, TL3, TL4, TL5, TL6, fault_clr,
        input  lamp_out, fault_o, fault_code, fault_light
    );

    modport slave (
        input  TL1, TL2, TL3, TL4, TL5, TL6, fault_clr,
        output lamp_out, fault_o, fault_code, fault_light
    );

endinterface

// File: rtl/tlc_light_tracker.sv
// Per-light history and yellow counter; flags illegal codes, bad steps and short yellow.
module tlc_light_tracker
    import tlc_pkg::*;
#(
    parameter int unsigned MIN_YELLOW = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] code,
    input  logic       arm,
    output logic       illegal_c,
    output logic       trans_c,
    output logic       short_c,
    output logic [2:0] decode_c
);

    localparam int unsigned YW   = $clog2(MIN_YELLOW + 1);
    localparam logic [YW-1:0] YMAX = YW'(MIN_YELLOW);

    logic [1:0]    hist;
    logic [YW-1:0] ycnt;

    // A light already yellow when arming has unknown history, so assume a full yellow.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hist <= RED;
            ycnt <= '0;
        end else begin
            hist <= code;
            if (code != YELLOW) begin
                ycnt <= '0;
            end else if (arm) begin
                ycnt <= YMAX;
            end else if (hist != YELLOW) begin
                ycnt <= YW'(1);
            end else if (ycnt != YMAX) begin
                ycnt <= ycnt + 1'b1;
            end
        end
    end

    always_comb begin
        illegal_c = (code == BAD);
        short_c   = (hist == YELLOW) && (code == RED) && (ycnt < YMAX);
        trans_c   = 1'b0;
        decode_c  = 3'b000;
        case (hist)
            GREEN:   trans_c = !((code == GREEN)  || (code == YELLOW));
            YELLOW:  trans_c = !((code == YELLOW) || (code == RED));
            RED:     trans_c = !((code == RED)    || (code == GREEN));
            default: trans_c = 1'b1;
        endcase
        case (code)
            GREEN:   decode_c = 3'b001;
            YELLOW:  decode_c = 3'b010;
            RED:     decode_c = 3'b100;
            default: decode_c = 3'b000;
        endcase
    end

endmodule

// File: rtl/tlc_lamp_monitor.sv
// Lamp driver and safety monitor: decodes light codes and latches flashing-red faults.
module tlc_lamp_monitor
    import tlc_pkg::*;
#(
    parameter int unsigned          MIN_YELLOW     = 4,
    parameter int unsigned          FLASH_HALF     = 8,
    parameter logic [NUM_PAIRS-1:0] CONFLICT_PAIRS = 15'h7BAF
) (
    input logic               clk,
    input logic               reset,
    tlc_lamp_monitor_if.slave bus
);

    localparam int unsigned FW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

    state_e                state;
    logic [FW-1:0]         flash_cnt;
    logic                  flash_ph;
    logic [1:0]            codes [NUM_LIGHTS];
    logic [NUM_LIGHTS-1:0] illegal;
    logic [NUM_LIGHTS-1:0] trans;
    logic [NUM_LIGHTS-1:0] short_y;
    logic [NUM_LIGHTS-1:0] nonred;
    logic [LAMP_W-1:0]     decode;
    logic                  arm;
    logic                  all_red;
    logic [2:0]            ill_l;
    logic [2:0]            con_l;
    logic [2:0]            tr_l;
    logic [2:0]            sy_l;
    fault_e                det_code;
    logic [2:0]            det_light;

    assign codes[0] = bus.TL1;
    assign codes[1] = bus.TL2;
    assign codes[2] = bus.TL3;
    assign codes[3] = bus.TL4;
    assign codes[4] = bus.TL5;
    assign codes[5] = bus.TL6;
    assign arm      = (state == ST_ARM);

    for (genvar i = 0; i < NUM_LIGHTS; i++) begin : g_trk
        tlc_light_tracker #(
            .MIN_YELLOW (MIN_YELLOW)
        ) u_trk (
            .clk       (clk),
            .reset     (reset),
            .code      (codes[i]),
            .arm       (arm),
            .illegal_c (illegal[i]),
            .trans_c   (trans[i]),
            .short_c   (short_y[i]),
            .decode_c  (decode[3*i +: 3])
        );
        assign nonred[i] = (codes[i] != RED);
    end

    assign all_red = ~|nonred;

    // Downward scans leave the lowest-numbered offender; sequence checks are masked while arming.
    always_comb begin
        ill_l     = '0;
        con_l     = '0;
        tr_l      = '0;
        sy_l      = '0;
        det_code  = F_NONE;
        det_light = '0;
        for (int i = NUM_LIGHTS - 1; i >= 0; i--) begin
            if (illegal[i]) ill_l = 3'(i + 1);
            if (trans[i])   tr_l  = 3'(i + 1);
            if (short_y[i]) sy_l  = 3'(i + 1);
        end
        for (int k = NUM_PAIRS - 1; k >= 0; k--) begin
            if (CONFLICT_PAIRS[k] && nonred[PAIR_LO[k]] && nonred[PAIR_HI[k]])
                con_l = 3'(PAIR_LO[k] + 1);
        end
        if (ill_l != '0) begin
            det_code  = F_ILLEGAL;
            det_light = ill_l;
        end else if (con_l != '0) begin
            det_code  = F_CONFLICT;
            det_light = con_l;
        end else if (!arm && (tr_l != '0)) begin
            det_code  = F_TRANSITION;
            det_light = tr_l;
        end else if (!arm && (sy_l != '0)) begin
            det_code  = F_SHORT_YELLOW;
            det_light = sy_l;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state           <= ST_ARM;
            flash_cnt       <= '0;
            flash_ph        <= 1'b1;
            bus.lamp_out    <= lamp_flash(1'b1);
            bus.fault_o     <= 1'b0;
            bus.fault_code  <= '0;
            bus.fault_light <= '0;
        end else begin
            case (state)
                ST_ARM, ST_MONITOR: begin
                    if (det_code != F_NONE) begin
                        state           <= ST_FAULT;
                        flash_cnt       <= '0;
                        flash_ph        <= 1'b1;
                        bus.lamp_out    <= lamp_flash(1'b1);
                        bus.fault_o     <= 1'b1;
                        bus.fault_code  <= det_code;
                        bus.fault_light <= det_light;
                    end else begin
                        state        <= ST_MONITOR;
                        bus.lamp_out <= decode;
                    end
                end
                ST_FAULT: begin
                    // Clear is honoured only once every light is already showing red.
                    if (bus.fault_clr && all_red) begin
                        state           <= ST_ARM;
                        flash_cnt       <= '0;
                        flash_ph        <= 1'b1;
                        bus.lamp_out    <= decode;
                        bus.fault_o     <= 1'b0;
                        bus.fault_code  <= '0;
                        bus.fault_light <= '0;
                    end else if (flash_cnt == FW'(FLASH_HALF - 1)) begin
                        flash_cnt    <= '0;
                        flash_ph     <= ~flash_ph;
                        bus.lamp_out <= lamp_flash(~flash_ph);
                    end else begin
                        flash_cnt    <= flash_cnt + 1'b1;
                        bus.lamp_out <= lamp_flash(flash_ph);
                    end
                end
                default: state <= ST_ARM;
            endcase
        end
    end

endmodule

// File: tb/tb_tlc_lamp_monitor.sv
// Scoreboard bench for tlc_lamp_monitor: directed light sequences with hand-computed outputs.
module tb_tlc_lamp_monitor;

    localparam logic [1:0]  G   = 2'd0;
    localparam logic [1:0]  Y   = 2'd1;
    localparam logic [1:0]  R   = 2'd2;
    localparam logic [1:0]  X   = 2'd3;
    localparam logic [17:0] ON  = 18'o444444;
    localparam logic [17:0] OFF = 18'o000000;

    typedef struct {
        string       tag;
        logic [17:0] lamp;
        logic        f;
        logic [2:0]  code;
        logic [2:0]  light;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];

    tlc_lamp_monitor_if bus();

    tlc_lamp_monitor #(
        .MIN_YELLOW     (4),
        .FLASH_HALF     (8),
        .CONFLICT_PAIRS (15'h7BAF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input string field, input logic [17:0] act, input logic [17:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %0o, expected %0o", tag, field, act, exp);
        end
    endtask

    // Monitor: one expected record per clock edge, checked just after the edge.
    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, "lamp_out",    bus.lamp_out,           e.lamp);
            check(e.tag, "fault_o",     18'(bus.fault_o),       18'(e.f));
            check(e.tag, "fault_code",  18'(bus.fault_code),    18'(e.code));
            check(e.tag, "fault_light", 18'(bus.fault_light),   18'(e.light));
        end
    end

    task automatic step(input string tag, input logic rst, input logic clr,
                        input logic [1:0] c1, input logic [1:0] c2, input logic [1:0] c3,
                        input logic [1:0] c4, input logic [1:0] c5, input logic [1:0] c6,
                        input logic [17:0] lamp, input logic f, input logic [2:0] fc, input logic [2:0] fl);
        exp_t e;
        @(negedge clk);
        reset         = rst;
        bus.fault_clr = clr;
        bus.TL1 = c1; bus.TL2 = c2; bus.TL3 = c3;
        bus.TL4 = c4; bus.TL5 = c5; bus.TL6 = c6;
        e.tag = tag; e.lamp = lamp; e.f = f; e.code = fc; e.light = fl;
        sb.push_back(e);
    endtask

    task automatic nf(input string tag, input logic [1:0] c1, input logic [1:0] c2, input logic [1:0] c3,
                      input logic [1:0] c4, input logic [1:0] c5, input logic [1:0] c6, input logic [17:0] lamp);
        step(tag, 1'b1, 1'b0, c1, c2, c3, c4, c5, c6, lamp, 1'b0, 3'd0, 3'd0);
    endtask

    task automatic ft(input string tag, input logic clr, input logic [1:0] c1, input logic [1:0] c2,
                      input logic [1:0] c3, input logic [1:0] c4, input logic [1:0] c5, input logic [1:0] c6,
                      input logic [17:0] lamp, input logic [2:0] fc, input logic [2:0] fl);
        step(tag, 1'b1, clr, c1, c2, c3, c4, c5, c6, lamp, 1'b1, fc, fl);
    endtask

    initial begin
        reset = 1'b0;
        bus.fault_clr = 1'b0;
        bus.TL1 = R; bus.TL2 = R; bus.TL3 = R; bus.TL4 = R; bus.TL5 = R; bus.TL6 = R;

        step("reset", 1'b0, 1'b0, R, R, R, R, R, R, ON, 1'b0, 3'd0, 3'd0);
        step("reset", 1'b0, 1'b0, R, R, R, R, R, R, ON, 1'b0, 3'd0, 3'd0);
        nf("arm",     R, R, R, R, R, R, ON);
        nf("mon_red", R, R, R, R, R, R, ON);

        // Normal cycle: {1,6} green, yellow x4, red; then {2,4}.
        nf("g16", G, R, R, R, R, G, 18'o144441);
        repeat (4) nf("y16", Y, R, R, R, R, Y, 18'o244442);
        nf("r16", R, R, R, R, R, R, ON);
        nf("g24", R, G, R, G, R, R, 18'o441414);
        repeat (4) nf("y24", R, Y, R, Y, R, R, 18'o442424);
        nf("r24", R, R, R, R, R, R, ON);

        // Conflict between lights 1 and 2, then flashing with an ignored clear.
        ft("conflict", 1'b0, G, G, R, R, R, R, ON, 3'd2, 3'd1);
        for (int i = 1; i <= 17; i++) begin
            if (i == 10)
                ft("clr_not_red", 1'b1, R, R, R, G, R, R, OFF, 3'd2, 3'd1);
            else
                ft("flash", 1'b0, R, R, R, R, R, R, (i < 8 || i >= 16) ? ON : OFF, 3'd2, 3'd1);
        end
        step("clear", 1'b1, 1'b1, R, R, R, R, R, R, ON, 1'b0, 3'd0, 3'd0);
        nf("arm_yellow", Y, R, R, R, R, R, 18'o444442);
        nf("arm_y_to_r", R, R, R, R, R, R, ON);

        // Short yellow on light 3, then a full-length yellow.
        nf("g3", R, R, G, R, R, R, 18'o444144);
        repeat (3) nf("y3x3", R, R, Y, R, R, R, 18'o444244);
        ft("short_yellow", 1'b0, R, R, R, R, R, R, ON, 3'd4, 3'd3);
        step("clear2", 1'b1, 1'b1, R, R, R, R, R, R, ON, 1'b0, 3'd0, 3'd0);
        nf("arm2", R, R, R, R, R, R, ON);
        nf("g3b", R, R, G, R, R, R, 18'o444144);
        repeat (4) nf("y3x4", R, R, Y, R, R, R, 18'o444244);
        nf("yellow4_ok", R, R, R, R, R, R, ON);

        // Light 5 G->R alongside code 3 on light 2: ILLEGAL wins.
        nf("g5", R, R, R, R, G, R, 18'o414444);
        ft("illegal", 1'b0, R, X, R, R, R, R, ON, 3'd1, 3'd2);
        for (int i = 1; i <= 9; i++)
            ft("flash2", 1'b0, R, R, R, R, R, R, (i < 8) ? ON : OFF, 3'd1, 3'd2);

        // Reset while in the dark half of the flash.
        step("reset_mid_flash", 1'b0, 1'b0, R, R, R, R, R, R, ON, 1'b0, 3'd0, 3'd0);
        nf("arm3", R, R, R, R, R, R, ON);
        nf("mon3", R, R, R, R, R, R, ON);

        @(posedge clk);
        #3;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tlc_lamp_monitor.md
# tlc_lamp_monitor

Safety monitor and lamp driver on the output side of the traffic light controller. It samples the six 2-bit light codes every clock and decodes them into registered per-lamp red/yellow/green drive. It checks every sample for illegal codes, conflicting non-red lights, illegal sequence steps and short yellow. On any violation it latches a fault and forces all lamps to flashing red until software clears it.

## Interface
- `MIN_YELLOW`, 4: minimum consecutive yellow samples required before yellow→red.
- `FLASH_HALF`, 8: cycles per on or off half-period of fault flashing.
- `CONFLICT_PAIRS`, 15'h7BAF: one bit per light pair; 1 means the two lights must never both be non-red. Pair bit order is (1,2)=0, (1,3)=1, (1,4)=2, (1,5)=3, (1,6)=4, (2,3)=5, (2,4)=6, (2,5)=7, (2,6)=8, (3,4)=9, (3,5)=10, (3,6)=11, (4,5)=12, (4,6)=13, (5,6)=14. The default allows only the groups {1,6}, {2,4} and {3,5}.
- `clk`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-low reset; it is sampled on the `clk` rising edge.
- `TL1`..`TL6`  in  2 each  light codes: 0 green, 1 yellow, 2 red, 3 illegal.
- `fault_clr`  in  1  single-cycle fault clear request.
- `lamp_out`  out  18  lamp drive, 3 bits per light {R,Y,G}; light n occupies bits [3n-1:3n-3].
- `fault_o`  out  1  fault latched.
- `fault_code`  out  3  0 none, 1 ILLEGAL, 2 CONFLICT, 3 TRANSITION, 4 SHORT_YELLOW.
- `fault_light`  out  3  offending light number 1..6; 0 when there is no fault.

## Operation
- State machine states:
  - ARM: one cycle. The block captures the current codes as history and does no sequence checks.
  - MONITOR: normal checking.
  - FAULT: latched fault.
- State transitions:
  - Reset → ARM.
  - ARM → MONITOR if no fault is detected, otherwise ARM → FAULT.
  - MONITOR → FAULT on any detected fault.
  - FAULT → ARM on `fault_clr`=1, but only when all six inputs are red (code 2). Otherwise `fault_clr` is ignored.
- Checks in ARM and MONITOR:
  - ILLEGAL: any code equals 3.
  - CONFLICT: any pair with its `CONFLICT_PAIRS` bit set has both lights non-red.
- Checks in MONITOR only:
  - TRANSITION: a light steps other than hold, G→Y, Y→R or R→G.
  - SHORT_YELLOW: a Y→R step occurs with the yellow count below `MIN_YELLOW`.
- Yellow count, one per light:
  - Set to 1 on the first yellow sample.
  - Increments while the light stays yellow, saturating at `MIN_YELLOW`.
  - Width is clog2(`MIN_YELLOW`+1).
  - In ARM, a light that is already yellow loads `MIN_YELLOW`, because its history is unknown.
- Simultaneous faults:
  - `fault_code` takes the lowest code number (ILLEGAL has the highest priority).
  - `fault_light` is the lowest-numbered light involved in that code. For CONFLICT this is the lower light of the lowest-indexed violating pair.
- Fault outputs:
  - `fault_code`, `fault_light` and `fault_o` hold in FAULT.
  - New violations during FAULT do not overwrite them.
- Lamp output:
  - MONITOR and ARM: `lamp_out` is the one-hot decode of each code.
  - FAULT: R = flash phase, Y = G = 0.
- Flash phase:
  - Set to 1 on FAULT entry.
  - Toggles every `FLASH_HALF` cycles.

## Timing
- Reset values:
  - `lamp_out` = all R=1, Y=G=0 (18'b100_100_100_100_100_100).
  - `fault_o`=0, `fault_code`=0, `fault_light`=0.
  - State ARM, flash counter 0, flash phase 1.
- Latency from code sample to decoded `lamp_out`: one cycle.
- Fault detection is combinational on the current sample, against the history register.
- On the edge that registers a fault:
  - `fault_o`, `fault_code` and `fault_light` update.
  - `lamp_out` already shows red-on with Y=G=0.
  - The offending decode is never driven to the lamps.
- Flash timing:
  - The first toggle is `FLASH_HALF` cycles after FAULT entry.
  - Flash period is 2·`FLASH_HALF`.
- Clear timing:
  - On the edge after an accepted `fault_clr`, the block is in ARM with all fault outputs 0.
  - `lamp_out` shows the decode of the all-red input.
- Reset mid-fault returns immediately to the reset values.
- The history register updates every cycle in all states.

## Structure
- `tlc_pkg` holds:
  - light codes (GREEN=0, YELLOW=1, RED=2);
  - fault code constants;
  - monitor state encoding;
  - the pair-index mapping constants used with `CONFLICT_PAIRS`.
- Sub-module `tlc_light_tracker`, instantiated six times:
  - contains the history register and yellow count;
  - produces the illegal, transition and short-yellow flags plus the one-hot decode for its light.
- The top level contains the conflict matrix, the fault priority encoder, the state machine and the flash counter.

## Test plan
- **Normal cycle.** After reset, all inputs red; then {1,6} runs G→Y(4 cycles)→R; then {2,4} goes G. Required: no fault, and `lamp_out` tracks the inputs one cycle late.
- **Conflict.** TL1=0 and TL2=0 in the same cycle. Required on the next edge: `fault_o`=1, `fault_code`=2, `fault_light`=1, all lamps R=1 Y=0 G=0. The lamps stay on for 8 cycles, then off for 8, and repeat.
- **Short yellow.** TL3 holds yellow for 3 cycles, then goes red. Required: `fault_code`=4, `fault_light`=3. Repeating the sequence with 4 yellow cycles gives no fault.
- **Illegal step with simultaneous code 3.** TL5 goes G→R while TL2=3 in the same cycle. Required: `fault_code`=1, `fault_light`=2.
- **Clear.** In FAULT, pulse `fault_clr` with TL4=0: no effect. Pulse it with all inputs red: required return to ARM with `fault_o`=0, then normal monitoring; a first sample with TL1 yellow raises no fault.
- **Reset.** Assert `reset`=0 during FAULT and mid-flash. Required: all outputs at their reset values on the next edge.
